// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt-controller CPU dispatch path.
// Source index = 4*register + field (IPRA..IPRN, field 14:12 first).
package intc_pkg;

    localparam int NUM_SRC  = 56;
    localparam int VEC_BASE = 64;
    localparam int ACK_TO   = 255;
    localparam int IDX_W    = $clog2(NUM_SRC);

    typedef logic [2:0] prio_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CLR  = 2'd2,
        HOLD = 2'd3
    } seq_state_t;

    localparam int IDX_IPRA_14_12 = 0,  IDX_IPRA_10_8 = 1,  IDX_IPRA_6_4 = 2,  IDX_IPRA_2_0 = 3;
    localparam int IDX_IPRB_14_12 = 4,  IDX_IPRB_10_8 = 5,  IDX_IPRB_6_4 = 6,  IDX_IPRB_2_0 = 7;
    localparam int IDX_IPRC_14_12 = 8,  IDX_IPRC_10_8 = 9,  IDX_IPRC_6_4 = 10, IDX_IPRC_2_0 = 11;
    localparam int IDX_IPRD_14_12 = 12, IDX_IPRD_10_8 = 13, IDX_IPRD_6_4 = 14, IDX_IPRD_2_0 = 15;
    localparam int IDX_IPRE_14_12 = 16, IDX_IPRE_10_8 = 17, IDX_IPRE_6_4 = 18, IDX_IPRE_2_0 = 19;
    localparam int IDX_IPRF_14_12 = 20, IDX_IPRF_10_8 = 21, IDX_IPRF_6_4 = 22, IDX_IPRF_2_0 = 23;
    localparam int IDX_IPRG_14_12 = 24, IDX_IPRG_10_8 = 25, IDX_IPRG_6_4 = 26, IDX_IPRG_2_0 = 27;
    localparam int IDX_IPRH_14_12 = 28, IDX_IPRH_10_8 = 29, IDX_IPRH_6_4 = 30, IDX_IPRH_2_0 = 31;
    localparam int IDX_IPRI_14_12 = 32, IDX_IPRI_10_8 = 33, IDX_IPRI_6_4 = 34, IDX_IPRI_2_0 = 35;
    localparam int IDX_IPRJ_14_12 = 36, IDX_IPRJ_10_8 = 37, IDX_IPRJ_6_4 = 38, IDX_IPRJ_2_0 = 39;
    localparam int IDX_IPRK_14_12 = 40, IDX_IPRK_10_8 = 41, IDX_IPRK_6_4 = 42, IDX_IPRK_2_0 = 43;
    localparam int IDX_IPRL_14_12 = 44, IDX_IPRL_10_8 = 45, IDX_IPRL_6_4 = 46, IDX_IPRL_2_0 = 47;
    localparam int IDX_IPRM_14_12 = 48, IDX_IPRM_10_8 = 49, IDX_IPRM_6_4 = 50, IDX_IPRM_2_0 = 51;
    localparam int IDX_IPRN_14_12 = 52, IDX_IPRN_10_8 = 53, IDX_IPRN_6_4 = 54, IDX_IPRN_2_0 = 55;

endpackage

// File: rtl/intc_ffs.sv
// Lowest-index find-first-set over the eligible-source vector.
module intc_ffs #(
    parameter int N  = 56,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_vec,
    output logic          o_vld,
    output logic [IW-1:0] o_idx
);

    // Scan high to low so the lowest set bit is the last write.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = IW'(i);
        end
    end

    assign o_vld = |i_vec;

endmodule

// File: rtl/intc_ack_sequencer.sv
// CPU-side dispatch sequencer: picks one eligible source, holds level/vector
// until acknowledge, then pulses a one-cycle clear to the serviced source.
module intc_ack_sequencer #(
    parameter int NUM_SRC  = intc_pkg::NUM_SRC,
    parameter int VEC_BASE = intc_pkg::VEC_BASE,
    parameter int ACK_TO   = intc_pkg::ACK_TO
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_pend,
    input  logic [NUM_SRC-1:0] src_en,
    input  logic [2:0]         max_priority,
    input  logic [2:0]         cpu_imask,
    output logic               irq_req,
    output logic [2:0]         irq_level,
    output logic [7:0]         irq_vector,
    input  logic               irq_ack,
    output logic [NUM_SRC-1:0] src_clr,
    output logic               to_err,
    input  logic               to_err_clr
);
    import intc_pkg::*;

    localparam int IW = $clog2(NUM_SRC);
    localparam int CW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_CLR  = CLR;
    localparam logic [1:0] ST_HOLD = HOLD;

    logic [1:0]         r_state;
    logic [IW-1:0]      r_sel;
    prio_t              r_lvl;
    logic [7:0]         r_vec;
    logic [CW-1:0]      r_cnt;
    logic               r_to_err;

    logic [NUM_SRC-1:0] w_elig;
    logic               w_ffs_vld;
    logic [IW-1:0]      w_ffs_idx;
    logic               w_go;
    logic               w_withdraw;
    logic               w_timeout;
    logic               w_to_set;
    logic [7:0]         w_vec_next;

    assign w_elig = src_pend & src_en;

    intc_ffs #(.N(NUM_SRC), .IW(IW)) u_ffs (
        .i_vec (w_elig),
        .o_vld (w_ffs_vld),
        .o_idx (w_ffs_idx)
    );

    assign w_go       = w_ffs_vld && (max_priority != 3'd0) && (max_priority > cpu_imask);
    assign w_vec_next = 8'(VEC_BASE) + 8'(w_ffs_idx);
    assign w_withdraw = !src_pend[r_sel] || !src_en[r_sel] || (r_lvl <= cpu_imask);
    assign w_timeout  = (r_cnt == CW'(ACK_TO - 1));
    // Ack outranks withdraw, withdraw outranks timeout.
    assign w_to_set   = (r_state == ST_REQ) && !irq_ack && !w_withdraw && w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_lvl    <= '0;
            r_vec    <= '0;
            r_cnt    <= '0;
            r_to_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_sel   <= w_ffs_idx;
                        r_lvl   <= max_priority;
                        r_vec   <= w_vec_next;
                        r_cnt   <= '0;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (irq_ack)         r_state <= ST_CLR;
                    else if (w_withdraw) r_state <= ST_IDLE;
                    else if (w_timeout)  r_state <= ST_IDLE;
                    else                 r_cnt   <= r_cnt + CW'(1);
                end
                ST_CLR:  r_state <= ST_HOLD;
                ST_HOLD: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if (w_to_set)        r_to_err <= 1'b1;
            else if (to_err_clr) r_to_err <= 1'b0;
        end
    end

    assign irq_req    = (r_state == ST_REQ);
    assign irq_level  = irq_req ? r_lvl : 3'd0;
    assign irq_vector = irq_req ? r_vec : 8'd0;
    assign src_clr    = (r_state == ST_CLR) ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << r_sel) : '0;
    assign to_err     = r_to_err;

endmodule
